fm_slot_arbiter: RTL

- Schedules the shared SDRAM frame-memory interface between six requesters: output-video read, input-video write, output-video write, input-video read, M4 command read and M4 command write.
- Latches single-cycle request pulses and picks one winner per memory slot.
- Presents the winner's address, bank and direction to the memory interface as a one-cycle grant.
- Sits between the video/test-pattern/M4 request sources and the SDRAM controller; paced by the controller's cycle_stp_adv / cycle_stp.

---
 rtl/fm_slot_arbiter.sv | 227 ++++++++++++++++++++++
 1 files changed

// File: rtl/fm_slot_arbiter.sv
`timescale 1ns/1ps
// SDRAM frame-memory slot arbiter for six requesters (ov_rd, iv_wr, ov_wr, iv_rd, m4_rd, m4_wr).
// Optional idle-slot statistics counter is built only when FM_ARB_STATS_EN is defined.
module fm_slot_arbiter #(
  parameter int AGE_MAX  = 7,
  parameter int BUSY_TMO = 63
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        c_done,
  input  logic        cycle_stp_adv,
  input  logic        cycle_stp,
  input  logic        ov_rd_req,
  input  logic        iv_wr_req,
  input  logic        ov_wr_req,
  input  logic        iv_rd_req,
  input  logic        m4_rd_req,
  input  logic        m4_wr_req,
  input  logic [18:0] ov_rd_adrs,
  input  logic [18:0] ov_wr_adrs,
  input  logic [18:0] m4_rd_adrs,
  input  logic [18:0] m4_wr_adrs,
  input  logic [16:0] iv_wr_adrs,
  input  logic [16:0] iv_rd_adrs,
  input  logic        m4_rd_bank1,
  input  logic        m4_wr_bank1,
  output logic [5:0]  gnt,
  output logic        gnt_valid,
  output logic [18:0] gnt_adrs,
  output logic        gnt_bank1,
  output logic        gnt_we,
  output logic [5:0]  pend,
  output logic [5:0]  overrun,
  output logic        busy_tmo_err,
  output logic [15:0] idle_slots,
  output logic [1:0]  dbg_state
);

  // Handshake: gnt_valid is a one-cycle strobe with no back-pressure; the
  // controller must take gnt/gnt_adrs/gnt_bank1/gnt_we in that same cycle.
  localparam int AGE_W = $clog2(AGE_MAX + 1);
  localparam int TMO_W = $clog2(BUSY_TMO + 1);

  typedef enum logic [1:0] {
    ST_INIT  = 2'd0,
    ST_ARB   = 2'd1,
    ST_GRANT = 2'd2,
    ST_BUSY  = 2'd3
  } state_t;

  state_t             r_state;
  state_t             w_next;
  logic [5:0]         r_pend;
  logic [5:0]         r_overrun;
  logic [18:0]        r_adrs [6];
  logic               r_m4_rd_bank1;
  logic               r_m4_wr_bank1;
  logic [AGE_W-1:0]   r_age;
  logic [TMO_W-1:0]   r_tmo;
  logic               r_tmo_err;
  logic               r_m4_next_wr;
  logic [5:0]         r_gnt;
  logic               r_gnt_valid;
  logic [18:0]        r_gnt_adrs;
  logic               r_gnt_bank1;
  logic               r_gnt_we;

  logic [5:0]         w_req;
  logic [18:0]        w_in_adrs [6];
  logic [5:0]         w_clr;
  logic [5:0]         w_pend_kept;
  logic [1:0]         w_m4_pend;
  logic [5:0]         w_m4_pick;
  logic               w_aged;
  logic [5:0]         w_win;
  logic               w_win_m4;
  logic [18:0]        w_win_adrs;
  logic               w_win_bank1;
  logic               w_win_we;
  logic               w_arb_fire;
  logic               w_tmo_hit;

  assign w_req = {m4_wr_req, m4_rd_req, iv_rd_req, ov_wr_req, iv_wr_req, ov_rd_req};

  always_comb begin
    w_in_adrs[0] = ov_rd_adrs;
    w_in_adrs[1] = {2'b00, iv_wr_adrs};
    w_in_adrs[2] = ov_wr_adrs;
    w_in_adrs[3] = {2'b00, iv_rd_adrs};
    w_in_adrs[4] = m4_rd_adrs;
    w_in_adrs[5] = m4_wr_adrs;
  end

  // The winner's pending bit drops at the end of the grant cycle; a fresh
  // pulse in that same cycle re-arms it with a new address.
  assign w_clr       = (r_state == ST_GRANT) ? r_gnt : 6'b0;
  assign w_pend_kept = r_pend & ~w_clr;

  assign w_m4_pend  = r_pend[5:4];
  assign w_aged     = (|w_m4_pend) && (r_age >= AGE_W'(AGE_MAX));
  assign w_arb_fire = (r_state == ST_ARB) && c_done && cycle_stp_adv && (|r_pend);

  always_comb begin
    w_m4_pick = 6'b0;
    if (w_m4_pend == 2'b11) w_m4_pick = r_m4_next_wr ? 6'b100000 : 6'b010000;
    else if (w_m4_pend[1])  w_m4_pick = 6'b100000;
    else if (w_m4_pend[0])  w_m4_pick = 6'b010000;
  end

  always_comb begin
    w_win = 6'b0;
    if (r_pend[0])      w_win = 6'b000001;
    else if (w_aged)    w_win = w_m4_pick;
    else if (r_pend[1]) w_win = 6'b000010;
    else if (r_pend[2]) w_win = 6'b000100;
    else if (r_pend[3]) w_win = 6'b001000;
    else                w_win = w_m4_pick;
  end

  always_comb begin
    w_win_adrs = 19'b0;
    for (int i = 0; i < 6; i++) begin
      if (w_win[i]) w_win_adrs = r_adrs[i];
    end
  end

  assign w_win_m4    = |w_win[5:4];
  assign w_win_bank1 = w_win[5] ? r_m4_wr_bank1 : (w_win[4] ? r_m4_rd_bank1 : 1'b0);
  assign w_win_we    = |(w_win & 6'b100110);

  always_comb begin
    w_next    = r_state;
    w_tmo_hit = 1'b0;
    if (!c_done) begin
      w_next = ST_INIT;
    end else begin
      case (r_state)
        ST_INIT:  w_next = ST_ARB;
        ST_ARB:   if (cycle_stp_adv && (|r_pend)) w_next = ST_GRANT;
        ST_GRANT: w_next = ST_BUSY;
        ST_BUSY: begin
          if (cycle_stp) begin
            w_next = ST_ARB;
          end else if (r_tmo == TMO_W'(BUSY_TMO - 1)) begin
            w_next    = ST_ARB;
            w_tmo_hit = 1'b1;
          end
        end
        default:  w_next = ST_INIT;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state       <= ST_INIT;
      r_pend        <= 6'b0;
      r_overrun     <= 6'b0;
      r_m4_rd_bank1 <= 1'b0;
      r_m4_wr_bank1 <= 1'b0;
      r_age         <= '0;
      r_tmo         <= '0;
      r_tmo_err     <= 1'b0;
      r_m4_next_wr  <= 1'b0;
      r_gnt         <= 6'b0;
      r_gnt_valid   <= 1'b0;
      r_gnt_adrs    <= 19'b0;
      r_gnt_bank1   <= 1'b0;
      r_gnt_we      <= 1'b0;
      for (int i = 0; i < 6; i++) r_adrs[i] <= 19'b0;
    end else begin
      r_state   <= w_next;
      r_pend    <= w_pend_kept | w_req;
      r_overrun <= r_overrun | (w_req & w_pend_kept);
      for (int i = 0; i < 6; i++) begin
        if (w_req[i] && !w_pend_kept[i]) r_adrs[i] <= w_in_adrs[i];
      end
      if (m4_rd_req && !w_pend_kept[4]) r_m4_rd_bank1 <= m4_rd_bank1;
      if (m4_wr_req && !w_pend_kept[5]) r_m4_wr_bank1 <= m4_wr_bank1;

      // Starvation guard for M4: counts lost arbitrations, clears once served.
      if (!(|w_m4_pend)) begin
        r_age <= '0;
      end else if (w_arb_fire) begin
        if (w_win_m4)                    r_age <= '0;
        else if (r_age < AGE_W'(AGE_MAX)) r_age <= r_age + 1'b1;
      end
      if (w_arb_fire && w_win_m4) r_m4_next_wr <= w_win[4];

      r_tmo <= (r_state == ST_BUSY && w_next == ST_BUSY) ? r_tmo + 1'b1 : '0;
      if (w_tmo_hit) r_tmo_err <= 1'b1;

      r_gnt       <= w_arb_fire ? w_win : 6'b0;
      r_gnt_valid <= w_arb_fire;
      if (w_arb_fire) begin
        r_gnt_adrs  <= w_win_adrs;
        r_gnt_bank1 <= w_win_bank1;
        r_gnt_we    <= w_win_we;
      end
    end
  end

`ifdef FM_ARB_STATS_EN
  logic [15:0] r_idle;
  logic        w_idle_slot;
  assign w_idle_slot = (r_state == ST_ARB) && cycle_stp_adv && !(|r_pend);

  always_ff @(posedge clk) begin
    if (rst)                                r_idle <= 16'b0;
    else if (w_idle_slot && r_idle != 16'hFFFF) r_idle <= r_idle + 16'd1;
  end
  assign idle_slots = r_idle;
`else
  assign idle_slots = 16'b0;
`endif

  assign gnt          = r_gnt;
  assign gnt_valid    = r_gnt_valid;
  assign gnt_adrs     = r_gnt_adrs;
  assign gnt_bank1    = r_gnt_bank1;
  assign gnt_we       = r_gnt_we;
  assign pend         = r_pend;
  assign overrun      = r_overrun;
  assign busy_tmo_err = r_tmo_err;
  assign dbg_state    = r_state;

endmodule
